// File: rtl/hazard_ctrl_nway.sv
// hazard_ctrl_nway: N-wide in-order hazard unit (operand forwarding, load-latency scoreboard,
// intra-bundle split issue, redirect flushes). Optional perf counters: define HAZ_PERF_CNT_EN.
module hazard_ctrl_nway #(
  parameter int LANES    = 2,
  parameter int LOAD_LAT = 1,
  parameter int FW       = $clog2(2 * LANES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES-1:0]    valid_d,
  input  logic [LANES-1:0]    regwrite_d,
  input  logic [5*LANES-1:0]  rs1_d,
  input  logic [5*LANES-1:0]  rs2_d,
  input  logic [5*LANES-1:0]  rd_d,
  input  logic [5*LANES-1:0]  rs1_e,
  input  logic [5*LANES-1:0]  rs2_e,
  input  logic [5*LANES-1:0]  rd_e,
  input  logic [LANES-1:0]    load_e,
  input  logic [5*LANES-1:0]  rd_m,
  input  logic [5*LANES-1:0]  rd_w,
  input  logic [LANES-1:0]    regwrite_m,
  input  logic [LANES-1:0]    regwrite_w,
  input  logic [LANES-1:0]    branch_taken_e,
  output logic                stall_f,
  output logic                stall_d,
  output logic [LANES-1:0]    flush_d,
  output logic [LANES-1:0]    flush_e,
  output logic [LANES-1:0]    flush_m,
  output logic [FW*LANES-1:0] fwd_a_e,
  output logic [FW*LANES-1:0] fwd_b_e,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_flush_cnt
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] SPLIT = 1'b1;

  logic [0:0]       state, stateNext;
  logic [LANES-1:0] issuedMask, issuedMaskNext;
  logic [2:0]       busy [1:31];
  logic [31:0]      busyVec;
  logic [31:1]      loadHit;

  logic             stall;
  logic             redirect;
  logic [LANES-1:0] redirectYounger;
  logic             loadUse;
  logic             rawHit;
  logic             hitJ;
  logic [LANES-1:0] rawGe;

  // Forwarding select: M beats W because it is applied last; ascending lane order lets the youngest win.
  function automatic logic [FW-1:0] fwdSel(
    input logic [4:0]         rs,
    input logic [5*LANES-1:0] rdM,
    input logic [LANES-1:0]   wrM,
    input logic [5*LANES-1:0] rdW,
    input logic [LANES-1:0]   wrW
  );
    logic [FW-1:0] sel;
    sel = '0;
    if (rs != 5'd0) begin
      for (int unsigned i = 0; i < LANES; i++)
        if (wrW[i] && rdW[5*i +: 5] == rs) sel = FW'(1 + LANES + i);
      for (int unsigned i = 0; i < LANES; i++)
        if (wrM[i] && rdM[5*i +: 5] == rs) sel = FW'(1 + i);
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a_e = '0;
    fwd_b_e = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      fwd_a_e[FW*l +: FW] = fwdSel(rs1_e[5*l +: 5], rd_m, regwrite_m, rd_w, regwrite_w);
      fwd_b_e[FW*l +: FW] = fwdSel(rs2_e[5*l +: 5], rd_m, regwrite_m, rd_w, regwrite_w);
    end
  end

  always_comb begin
    busyVec = '0;
    for (int unsigned r = 1; r < 32; r++)
      busyVec[r] = |busy[r];
  end

  always_comb begin
    loadUse = 1'b0;
    for (int unsigned j = 0; j < LANES; j++)
      if (valid_d[j] && (busyVec[rs1_d[5*j +: 5]] || busyVec[rs2_d[5*j +: 5]]))
        loadUse = 1'b1;
  end

  // Lowest dependent lane j inside the bundle; rawGe marks lanes j and above.
  always_comb begin
    rawHit = 1'b0;
    hitJ   = 1'b0;
    rawGe  = '0;
    for (int unsigned j = 1; j < LANES; j++) begin
      hitJ = 1'b0;
      if (valid_d[j]) begin
        for (int unsigned i = 0; i < j; i++)
          if (valid_d[i] && regwrite_d[i] && !issuedMask[i] && rd_d[5*i +: 5] != 5'd0 &&
              (rs1_d[5*j +: 5] == rd_d[5*i +: 5] || rs2_d[5*j +: 5] == rd_d[5*i +: 5]))
            hitJ = 1'b1;
      end
      if (hitJ && !rawHit) begin
        rawHit = 1'b1;
        for (int unsigned l = 0; l < LANES; l++)
          rawGe[l] = (l >= j);
      end
    end
  end

  // A lane is younger than the oldest taken branch iff some lower lane has a taken branch.
  always_comb begin
    redirectYounger = '0;
    redirect        = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      redirectYounger[l] = redirect;
      redirect           = redirect | branch_taken_e[l];
    end
  end

  always_comb begin
    stall          = 1'b0;
    flush_d        = '0;
    flush_e        = '0;
    flush_m        = '0;
    stateNext      = state;
    issuedMaskNext = issuedMask;
    if (redirect) begin
      flush_d        = '1;
      flush_e        = '1;
      flush_m        = redirectYounger;
      stateNext      = RUN;
      issuedMaskNext = '0;
    end else if (loadUse) begin
      stall   = 1'b1;
      flush_e = '1;
    end else if (rawHit) begin
      stall          = 1'b1;
      flush_e        = rawGe | issuedMask;
      issuedMaskNext = issuedMask | ~rawGe;
      stateNext      = SPLIT;
    end else begin
      flush_e        = (state == SPLIT) ? issuedMask : '0;
      stateNext      = RUN;
      issuedMaskNext = '0;
    end
  end

  assign stall_f = stall;
  assign stall_d = stall;

  always_comb begin
    loadHit = '0;
    for (int unsigned i = 0; i < LANES; i++)
      if (load_e[i] && !flush_e[i] && rd_e[5*i +: 5] != 5'd0)
        loadHit[rd_e[5*i +: 5]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      issuedMask <= '0;
      for (int unsigned r = 1; r < 32; r++)
        busy[r] <= '0;
    end else begin
      state      <= stateNext;
      issuedMask <= issuedMaskNext;
      for (int unsigned r = 1; r < 32; r++) begin
        if (loadHit[r])
          busy[r] <= 3'(LOAD_LAT);
        else if (busy[r] != 3'd0)
          busy[r] <= busy[r] - 3'd1;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stallCnt, flushCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stall && stallCnt != '1)
        stallCnt <= stallCnt + 32'd1;
      if ((|flush_d) && flushCnt != '1)
        flushCnt <= flushCnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stallCnt;
  assign perf_flush_cnt = flushCnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_nway.sv
// tb_hazard_ctrl_nway: randomized run against a behavioural hazard model, plus directed
// scenarios with hand-computed expectations.
module tb_hazard_ctrl_nway;

  localparam int LANES = 2;
  localparam int LAT   = 3;
  localparam int FW    = $clog2(2 * LANES + 1);
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [LANES-1:0]    valid_d, regwrite_d, load_e, regwrite_m, regwrite_w, branch_taken_e;
  logic [5*LANES-1:0]  rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic                stall_f, stall_d;
  logic [LANES-1:0]    flush_d, flush_e, flush_m;
  logic [FW*LANES-1:0] fwd_a_e, fwd_b_e;
  logic [31:0]         perf_stall_cnt, perf_flush_cnt;

  int nChecks = 0;
  int nFails  = 0;

  hazard_ctrl_nway #(.LANES(LANES), .LOAD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .valid_d(valid_d), .regwrite_d(regwrite_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .load_e(load_e),
    .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .branch_taken_e(branch_taken_e),
    .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int fld(input logic [5*LANES-1:0] v, input int l);
    return int'((v >> (5 * l)) & 'h1f);
  endfunction

  function automatic int fwdField(input logic [FW*LANES-1:0] v, input int l);
    return int'((v >> (FW * l)) & ((1 << FW) - 1));
  endfunction

  // ---------------- behavioural model ----------------
  // A register is unavailable while the cycle number is below freeAt[r].
  int unsigned cyc = 0;
  int unsigned freeAt [32];
  bit               inSplit = 1'b0;
  bit [LANES-1:0]   issued = '0;
  bit               modelValid = 1'b0;
  int               pStall = 0, pFlush = 0;
  bit               eStall, rstS, nSplit;
  bit [LANES-1:0]   eFd, eFe, eFm, nIssued;
  int               loadRd [LANES];

  function automatic bit regBusy(input int r);
    return (r != 0) && (cyc < freeAt[r]);
  endfunction

  function automatic int fwdExp(input int rs);
    if (rs == 0) return 0;
    for (int i = LANES - 1; i >= 0; i--)
      if (regwrite_m[i] && fld(rd_m, i) == rs) return 1 + i;
    for (int i = LANES - 1; i >= 0; i--)
      if (regwrite_w[i] && fld(rd_w, i) == rs) return 1 + LANES + i;
    return 0;
  endfunction

  task automatic modelEval();
    int k, rawJ;
    bit lu;
    k = -1;
    rawJ = -1;
    lu = 1'b0;
    for (int l = 0; l < LANES; l++)
      if (branch_taken_e[l] && k < 0) k = l;
    for (int j = 0; j < LANES; j++)
      if (valid_d[j] && (regBusy(fld(rs1_d, j)) || regBusy(fld(rs2_d, j)))) lu = 1'b1;
    for (int j = 1; j < LANES; j++)
      if (valid_d[j] && rawJ < 0)
        for (int i = 0; i < j; i++)
          if (valid_d[i] && regwrite_d[i] && !issued[i] && fld(rd_d, i) != 0 &&
              (fld(rs1_d, j) == fld(rd_d, i) || fld(rs2_d, j) == fld(rd_d, i)))
            rawJ = j;
    eStall = 1'b0; eFd = '0; eFe = '0; eFm = '0;
    nSplit = inSplit; nIssued = issued;
    if (k >= 0) begin
      eFd = '1; eFe = '1;
      for (int l = 0; l < LANES; l++) eFm[l] = (l > k);
      nSplit = 1'b0; nIssued = '0;
    end else if (lu) begin
      eStall = 1'b1; eFe = '1;
    end else if (rawJ >= 0) begin
      eStall = 1'b1;
      for (int l = 0; l < LANES; l++) begin
        eFe[l]     = (l >= rawJ) || issued[l];
        nIssued[l] = issued[l] || (l < rawJ);
      end
      nSplit = 1'b1;
    end else begin
      eFe = issued;
      nSplit = 1'b0; nIssued = '0;
    end
    for (int l = 0; l < LANES; l++)
      loadRd[l] = (load_e[l] && !eFe[l]) ? fld(rd_e, l) : 0;
    rstS = rst;
  endtask

  task automatic modelCommit();
    if (rstS) begin
      for (int r = 0; r < 32; r++) freeAt[r] = 0;
      inSplit = 1'b0; issued = '0; pStall = 0; pFlush = 0;
      modelValid = 1'b1;
    end else begin
      for (int l = 0; l < LANES; l++)
        if (loadRd[l] != 0) freeAt[loadRd[l]] = cyc + 1 + LAT;
      inSplit = nSplit; issued = nIssued;
      if (eStall) pStall++;
      if (|eFd) pFlush++;
    end
    cyc++;
  endtask

  always begin
    @(negedge clk);
    modelEval();
    if (modelValid) begin
      check("stall_f", stall_f, eStall);
      check("stall_d", stall_d, eStall);
      check("flush_d", flush_d, eFd);
      check("flush_e", flush_e, eFe);
      check("flush_m", flush_m, eFm);
      for (int l = 0; l < LANES; l++) begin
        check($sformatf("fwd_a_e[%0d]", l), fwdField(fwd_a_e, l), fwdExp(fld(rs1_e, l)));
        check($sformatf("fwd_b_e[%0d]", l), fwdField(fwd_b_e, l), fwdExp(fld(rs2_e, l)));
      end
      check("perf_stall_cnt", perf_stall_cnt, PERF ? pStall : 0);
      check("perf_flush_cnt", perf_flush_cnt, PERF ? pFlush : 0);
    end
    @(posedge clk);
    modelCommit();
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_d = '0; regwrite_d = '0; load_e = '0; regwrite_m = '0; regwrite_w = '0;
    branch_taken_e = '0;
    rs1_d = '0; rs2_d = '0; rd_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
  endtask

  task automatic doReset();
    tick(); idle(); rst = 1'b1;
    tick(); rst = 1'b0;
  endtask

  // lane0 writes x3, lane1 reads x3
  task automatic rawBundle();
    valid_d = 2'b11; regwrite_d = 2'b11;
    rd_d[4:0] = 5'd3; rs1_d[4:0] = 5'd1; rs2_d[4:0] = 5'd2;
    rd_d[9:5] = 5'd4; rs1_d[9:5] = 5'd3; rs2_d[9:5] = 5'd0;
  endtask

  task automatic randomInputs();
    for (int l = 0; l < LANES; l++) begin
      valid_d[l]        = ($urandom_range(0, 99) < 85);
      regwrite_d[l]     = ($urandom_range(0, 99) < 70);
      load_e[l]         = ($urandom_range(0, 99) < 30);
      regwrite_m[l]     = ($urandom_range(0, 1) == 1);
      regwrite_w[l]     = ($urandom_range(0, 1) == 1);
      branch_taken_e[l] = ($urandom_range(0, 99) < 5);
      rs1_d[5*l +: 5] = 5'($urandom_range(0, 7));
      rs2_d[5*l +: 5] = 5'($urandom_range(0, 7));
      rd_d[5*l +: 5]  = 5'($urandom_range(0, 7));
      rs1_e[5*l +: 5] = 5'($urandom_range(0, 7));
      rs2_e[5*l +: 5] = 5'($urandom_range(0, 7));
      rd_e[5*l +: 5]  = 5'($urandom_range(0, 7));
      rd_m[5*l +: 5]  = 5'($urandom_range(0, 7));
      rd_w[5*l +: 5]  = 5'($urandom_range(0, 7));
    end
    rst = ($urandom_range(0, 99) < 2);
  endtask

  initial begin
    idle();
    doReset();

    // forwarding priorities
    rd_m = {5'd7, 5'd7}; regwrite_m = 2'b11; rs1_e[4:0] = 5'd7;
    #1 check("fwd M youngest", fwdField(fwd_a_e, 0), 2);
    rd_m = '0; rs1_e[4:0] = 5'd0;
    #1 check("fwd x0", fwdField(fwd_a_e, 0), 0);
    regwrite_m = '0; rd_w[4:0] = 5'd7; regwrite_w = 2'b01; rs2_e[9:5] = 5'd7;
    #1 check("fwd W lane0", fwdField(fwd_b_e, 1), 3);

    // intra-bundle split
    doReset(); idle(); rawBundle();
    #1 check("split c1 stall", stall_d, 1);
    check("split c1 flush_e", flush_e, 2'b10);
    tick();
    #1 check("split c2 stall", stall_d, 0);
    check("split c2 flush_e", flush_e, 2'b01);

    // load-use with LOAD_LAT=3
    doReset(); idle(); load_e = 2'b01; rd_e[4:0] = 5'd9;
    #1 check("lu c0 stall", stall_d, 0);
    tick(); idle(); valid_d = 2'b10; rs1_d[9:5] = 5'd9;
    for (int c = 1; c <= 3; c++) begin
      #1 check($sformatf("lu c%0d stall", c), stall_f, 1);
      check($sformatf("lu c%0d flush_e", c), flush_e, 2'b11);
      tick();
    end
    #1 check("lu c4 stall", stall_d, 0);
    rd_w[4:0] = 5'd9; regwrite_w = 2'b01; rs1_e[9:5] = 5'd9;
    #1 check("lu fwd W lane0", fwdField(fwd_a_e, 1), 3);

    // reset in the middle of a load-use stall
    doReset(); idle(); load_e = 2'b01; rd_e[4:0] = 5'd9;
    tick(); idle(); valid_d = 2'b10; rs1_d[9:5] = 5'd9;
    #1 check("rst mid pre", stall_d, 1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    #1 check("rst mid stall", stall_d, 0);
    check("rst mid flush_e", flush_e, 2'b00);

    // redirect during SPLIT with a load-use pending
    doReset(); idle(); rawBundle(); load_e = 2'b01; rd_e[4:0] = 5'd9;
    tick(); load_e = '0; rs2_d[9:5] = 5'd9; branch_taken_e = 2'b01;
    #1 check("redir flush_d", flush_d, 2'b11);
    check("redir flush_e", flush_e, 2'b11);
    check("redir flush_m", flush_m, 2'b10);
    check("redir stall", stall_f, 0);
    tick(); idle();
    #1 check("redir RUN flush_e", flush_e, 2'b00);

    // performance counters: 4 stall cycles, 2 redirect cycles
    doReset(); idle(); load_e = 2'b01; rd_e[4:0] = 5'd9;
    tick(); idle(); valid_d = 2'b10; rs1_d[9:5] = 5'd9;
    tick(); tick();
    tick(); idle(); rawBundle();
    tick(); idle(); branch_taken_e = 2'b01;
    tick(); branch_taken_e = 2'b10;
    tick(); idle();
    #1 check("perf stall", perf_stall_cnt, PERF ? 4 : 0);
    check("perf flush", perf_flush_cnt, PERF ? 2 : 0);

    // randomized run
    doReset();
    for (int n = 0; n < 3000; n++) begin
      tick();
      randomInputs();
    end
    tick(); idle(); rst = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
